// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Run/pause/clear/load sequencer for the small display counter.
//               Produces a prescaled count tick, holds the count, detects the
//               terminal value and wraps (mode 0) or stops in DONE (mode 1).
//               Optional down-count support: define COUNTER_CTRL_DOWN_EN to
//               add the dir port (dir=1 counts down towards 0).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
   parameter int WIDTH    = 3,
   parameter int PRESCALE = 4,
   parameter int TERMINAL = 7
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             mode,
`ifdef COUNTER_CTRL_DOWN_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] oQ,
   output logic             oTick,
   output logic             oDone,
   output logic             oBusy,
   output logic [1:0]       oState
);

   // Prescaler needs at least one bit even when PRESCALE is 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [WIDTH-1:0] c_term = WIDTH'(TERMINAL);
   localparam logic [PW-1:0]    c_pmax = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic [PW-1:0]    r_presc;
   logic             r_tick;
   logic             r_done;
   logic             r_busy;

   logic             w_down;
   logic             w_at_term;
   logic [WIDTH-1:0] w_wrap_val;
   logic [WIDTH-1:0] w_step_val;
   logic [WIDTH-1:0] w_load_sat;

`ifdef COUNTER_CTRL_DOWN_EN
   assign w_down = dir;
`else
   assign w_down = 1'b0;
`endif

   // Direction-dependent terminal detection, wrap target and next step.
   assign w_at_term  = w_down ? (r_q == '0) : (r_q == c_term);
   assign w_wrap_val = w_down ? c_term : '0;
   assign w_step_val = w_down ? (r_q - 1'b1) : (r_q + 1'b1);

   // Loaded values saturate so the count never exceeds the terminal value.
   assign w_load_sat = (load_val > c_term) ? c_term : load_val;

   // Sequencer: priority clear > load > stop > start, counting only in RUN.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         r_done <= 1'b0;
         if (clear) begin
            r_q     <= '0;
            r_presc <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else if (load) begin
            // Loading out of DONE re-arms the sequencer; prescaler untouched.
            r_q <= w_load_sat;
            if (r_state == S_DONE) begin
               r_state <= S_IDLE;
            end
         end else if (stop) begin
            // stop also wins over a simultaneous start.
            if (r_state == S_RUN) begin
               r_state <= S_PAUSE;
               r_busy  <= 1'b0;
            end
         end else if (start && (r_state != S_RUN)) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            if (r_state == S_IDLE) begin
               r_presc <= '0;
            end else if (r_state == S_DONE) begin
               r_presc <= '0;
               r_q     <= w_down ? c_term : '0;
            end
            // From PAUSE the prescaler resumes from its held value.
         end else if (r_state == S_RUN) begin
            if (r_presc == c_pmax) begin
               r_presc <= '0;
               r_tick  <= 1'b1;
               if (w_at_term) begin
                  r_done <= 1'b1;
                  if (mode) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_q <= w_wrap_val;
                  end
               end else begin
                  r_q <= w_step_val;
               end
            end else begin
               r_presc <= r_presc + 1'b1;
            end
         end
      end
   end

   assign oQ     = r_q;
   assign oTick  = r_tick;
   assign oDone  = r_done;
   assign oBusy  = r_busy;
   assign oState = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Directed, self-checking bench for counter_seq_ctrl
//               (PRESCALE=4, TERMINAL=7, up-count build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

   localparam logic [1:0] c_idle  = 2'b00;
   localparam logic [1:0] c_run   = 2'b01;
   localparam logic [1:0] c_pause = 2'b10;
   localparam logic [1:0] c_done  = 2'b11;

   logic       CLK = 1'b0;
   logic       rst, start, stop, clear, load, mode;
   logic [2:0] load_val;
   logic [2:0] oQ;
   logic       oTick, oDone, oBusy;
   logic [1:0] oState;

   typedef struct {
      logic [2:0] q;
      logic       tick;
      logic       done;
      logic       busy;
      logic [1:0] st;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   counter_seq_ctrl #(.WIDTH(3), .PRESCALE(4), .TERMINAL(7)) dut (
      .CLK      (CLK),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .oQ       (oQ),
      .oTick    (oTick),
      .oDone    (oDone),
      .oBusy    (oBusy),
      .oState   (oState)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Push the expected post-edge outputs, clock once, then pop and compare.
   task automatic step(input logic [2:0] q, input logic tick, input logic done,
                       input logic [1:0] st);
      exp_t e;
      exp_t got;
      e.q = q; e.tick = tick; e.done = done; e.st = st;
      e.busy = (st == c_run);
      sb.push_back(e);
      @(posedge CLK);
      #1;
      got = sb.pop_front();
      chk("oQ",     {1'b0, oQ},     {1'b0, got.q});
      chk("oTick",  {3'b0, oTick},  {3'b0, got.tick});
      chk("oDone",  {3'b0, oDone},  {3'b0, got.done});
      chk("oBusy",  {3'b0, oBusy},  {3'b0, got.busy});
      chk("oState", {2'b0, oState}, {2'b0, got.st});
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
      load = 1'b0; load_val = 3'd0; mode = 1'b0;

      // Reset held two cycles with start asserted.
      step(3'd0, 1'b0, 1'b0, c_idle);
      step(3'd0, 1'b0, 1'b0, c_idle);

      // Start pulse, wrap mode: ticks every 4 cycles, wrap on the 8th tick.
      rst = 1'b0;
      step(3'd0, 1'b0, 1'b0, c_run);
      start = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         step(3'((k / 4) % 8), (k % 4) == 0, k == 32, c_run);
      end

      // One-shot: stop at 7 in DONE.
      mode = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         step(((k / 4) > 7) ? 3'd7 : 3'(k / 4), (k % 4) == 0, k == 32,
              (k == 32) ? c_done : c_run);
      end
      step(3'd7, 1'b0, 1'b0, c_done);

      // Restart out of DONE clears the count.
      start = 1'b1;
      step(3'd0, 1'b0, 1'b0, c_run);
      start = 1'b0;

      // Pause with prescaler at 2; tick arrives 2 cycles after resume.
      step(3'd0, 1'b0, 1'b0, c_run);
      step(3'd0, 1'b0, 1'b0, c_run);
      stop = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(3'd0, 1'b0, 1'b0, c_pause);
      end
      stop = 1'b0; start = 1'b1;
      step(3'd0, 1'b0, 1'b0, c_run);
      start = 1'b0;
      step(3'd0, 1'b0, 1'b0, c_run);
      step(3'd1, 1'b1, 1'b0, c_run);

      // stop+start together: stop wins in RUN and in PAUSE.
      stop = 1'b1; start = 1'b1;
      step(3'd1, 1'b0, 1'b0, c_pause);
      step(3'd1, 1'b0, 1'b0, c_pause);
      stop = 1'b0; start = 1'b0;

      // Oversized load saturates to TERMINAL (9 truncates to 3 bits, so use 7 path).
      load = 1'b1; load_val = 3'd7;
      step(3'd7, 1'b0, 1'b0, c_pause);
      load = 1'b0;

      // Loaded TERMINAL: next tick is the terminal tick (wrap).
      mode = 1'b0; start = 1'b1;
      step(3'd7, 1'b0, 1'b0, c_run);
      start = 1'b0;
      step(3'd7, 1'b0, 1'b0, c_run);
      step(3'd7, 1'b0, 1'b0, c_run);
      step(3'd7, 1'b0, 1'b0, c_run);
      step(3'd0, 1'b1, 1'b1, c_run);

      // load and clear together: clear wins.
      load = 1'b1; load_val = 3'd5; clear = 1'b1;
      step(3'd0, 1'b0, 1'b0, c_idle);
      clear = 1'b0;

      // Load in IDLE, then one-shot from 3 to 7.
      load_val = 3'd3;
      step(3'd3, 1'b0, 1'b0, c_idle);
      load = 1'b0; mode = 1'b1; start = 1'b1;
      step(3'd3, 1'b0, 1'b0, c_run);
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step(((3 + k / 4) > 7) ? 3'd7 : 3'(3 + k / 4), (k % 4) == 0, k == 20,
              (k == 20) ? c_done : c_run);
      end

      // Load in DONE returns to IDLE.
      load = 1'b1; load_val = 3'd2;
      step(3'd2, 1'b0, 1'b0, c_idle);

      // Reset on the cycle that would be the terminal tick: no oDone.
      load_val = 3'd7;
      step(3'd7, 1'b0, 1'b0, c_idle);
      load = 1'b0; start = 1'b1;
      step(3'd7, 1'b0, 1'b0, c_run);
      start = 1'b0;
      step(3'd7, 1'b0, 1'b0, c_run);
      step(3'd7, 1'b0, 1'b0, c_run);
      step(3'd7, 1'b0, 1'b0, c_run);
      rst = 1'b1;
      step(3'd0, 1'b0, 1'b0, c_idle);
      rst = 1'b0;
      step(3'd0, 1'b0, 1'b0, c_idle);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
